spi_mem_ctrl: RTL and testbench

Byte-wide memory controller between the quick CPU's external memory port and an off-chip SPI serial SRAM (23K256-style, SPI mode 0). It takes one 8-bit-address read or write request at a time and runs a full SPI frame: command, 16-bit address, data. Read data is returned with a one-cycle valid pulse. The chip-top stalls the CPU while `busy` is high, so this block stands in for the bench-side memory array used in CPU-only simulation.

---
 rtl/spi_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: byte-wide memory port to a 23K256-style SPI serial SRAM
// (SPI mode 0). Each accepted request runs one full frame:
// 8-bit command, 16-bit address (upper byte zero), 8-bit data.
// Read data comes back with a single-cycle rsp_valid pulse.
module spi_mem_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [5:0] BIT_TOTAL = 6'd32;

    logic [2:0]  state_reg, state_next;
    logic [3:0]  div_reg, div_next;
    logic [5:0]  bit_reg, bit_next;
    logic [31:0] sr_reg, sr_next;
    logic [7:0]  rx_reg, rx_next;
    logic        we_reg, we_next;
    logic        cs_n_reg, cs_n_next;
    logic        sck_reg, sck_next;
    logic        mosi_reg, mosi_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [7:0]  rsp_data_reg, rsp_data_next;

    logic [31:0] load_word;
    logic        div_hit;

    // Frame image built from the request inputs; only used in the accept cycle.
    assign load_word = {req_we ? CMD_WRITE : CMD_READ, 8'h00, req_addr,
                        req_we ? req_wdata : 8'h00};
    assign div_hit   = (div_reg == DIV_LAST);

    // Next-state and datapath decisions for the frame sequencer.
    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        bit_next       = bit_reg;
        sr_next        = sr_reg;
        rx_next        = rx_reg;
        we_next        = we_reg;
        cs_n_next      = cs_n_reg;
        sck_next       = sck_reg;
        mosi_next      = mosi_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    sr_next    = load_word;
                    we_next    = req_we;
                    bit_next   = 6'd0;
                    div_next   = 4'd0;
                    cs_n_next  = 1'b0;
                    sck_next   = 1'b0;
                    mosi_next  = load_word[31];
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // CS is low and MOSI holds the first bit; the first SCK
                // rise (and first MISO sample) ends this phase.
                if (div_hit) begin
                    div_next   = 4'd0;
                    sck_next   = 1'b1;
                    rx_next    = {rx_reg[6:0], spi_miso};
                    state_next = ST_SHIFT;
                end else begin
                    div_next = div_reg + 4'd1;
                end
            end
            ST_SHIFT: begin
                if (div_hit) begin
                    div_next = 4'd0;
                    if (sck_reg) begin
                        // Falling edge: advance to the next MOSI bit. The
                        // register rotates rather than shifts; after 32 bits
                        // its contents are no longer used.
                        sck_next  = 1'b0;
                        sr_next   = {sr_reg[30:0], sr_reg[31]};
                        mosi_next = sr_reg[30];
                        bit_next  = bit_reg + 6'd1;
                    end else if (bit_reg == BIT_TOTAL) begin
                        // Low half of the last bit has elapsed: close the frame.
                        cs_n_next      = 1'b1;
                        mosi_next      = 1'b0;
                        rsp_valid_next = ~we_reg;
                        if (!we_reg) begin
                            rsp_data_next = rx_reg;
                        end
                        state_next = ST_DONE;
                    end else begin
                        // Rising edge: sample MISO; only the last 8 survive.
                        sck_next = 1'b1;
                        rx_next  = {rx_reg[6:0], spi_miso};
                    end
                end else begin
                    div_next = div_reg + 4'd1;
                end
            end
            ST_DONE: begin
                div_next   = 4'd0;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                // Minimum CS-deselect time before the next request.
                if (div_hit) begin
                    div_next   = 4'd0;
                    state_next = ST_IDLE;
                end else begin
                    div_next = div_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces an idle, deselected bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            div_reg       <= 4'd0;
            bit_reg       <= 6'd0;
            sr_reg        <= 32'd0;
            rx_reg        <= 8'd0;
            we_reg        <= 1'b0;
            cs_n_reg      <= 1'b1;
            sck_reg       <= 1'b0;
            mosi_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_reg       <= bit_next;
            sr_reg        <= sr_next;
            rx_reg        <= rx_next;
            we_reg        <= we_next;
            cs_n_reg      <= cs_n_next;
            sck_reg       <= sck_next;
            mosi_reg      <= mosi_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    // Handshake comes from the state register only, never from req_valid.
    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign spi_cs_n  = cs_n_reg;
    assign spi_sck   = sck_reg;
    assign spi_mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Testbench for spi_mem_ctrl: one instance at CLK_DIV=1 and one at CLK_DIV=3,
// each with a behavioural SPI SRAM slave. Cycle numbers are counted from the
// accept edge (cycle n is the clock period that follows edge n-1).
module tb_spi_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_data  [2];
    logic       busy      [2];
    logic       spi_cs_n  [2];
    logic       spi_sck   [2];
    logic       spi_mosi  [2];
    logic [31:0] slave_word [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc [2];

    // bus observations
    int          rv_cnt [2];
    int          rv_cyc [2];
    logic [7:0]  rv_data [2];
    logic [31:0] cap_mosi [2];
    int          cap_rises [2], cap_first [2], cap_period [2];
    logic [31:0] fr_mosi [2];
    int          fr_rises [2], fr_first [2], fr_period [2], fr_cnt [2];
    int          hi_run [2], last_gap [2], stray [2];
    logic        cs_prev [2], sck_prev [2];

    // reference state: last read data returned per instance
    logic [7:0]  rsp_model [2];

    typedef struct {
        int          k;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sdata;
        logic [31:0] exp_mosi;
        logic        exp_valid;
        logic [7:0]  exp_rsp;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        int   fall_cnt = 0;
        logic miso_w;

        spi_mem_ctrl #(.CLK_DIV(gi == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_data  (rsp_data[gi]),
            .busy      (busy[gi]),
            .spi_cs_n  (spi_cs_n[gi]),
            .spi_sck   (spi_sck[gi]),
            .spi_mosi  (spi_mosi[gi]),
            .spi_miso  (miso_w)
        );

        // SPI slave: mode 0, next bit presented after each SCK fall.
        always @(negedge spi_sck[gi] or posedge spi_cs_n[gi]) begin
            if (spi_cs_n[gi]) fall_cnt <= 0;
            else if (fall_cnt < 32) fall_cnt <= fall_cnt + 1;
        end

        always_comb begin
            miso_w = 1'b0;
            if (spi_cs_n[gi] === 1'b0 && fall_cnt < 32)
                miso_w = slave_word[gi][5'(31 - fall_cnt)];
        end
    end

    // cycle counter and accept-edge recorder
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++)
                if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) acc_cyc[k] = cyc;
            cyc++;
        end
    end

    // bus monitor, sampled mid-period
    initial begin
        int rel;
        for (int k = 0; k < 2; k++) begin
            rv_cnt[k] = 0; rv_cyc[k] = 0; rv_data[k] = 8'h00;
            cap_mosi[k] = 0; cap_rises[k] = 0; cap_first[k] = 0; cap_period[k] = 0;
            fr_mosi[k] = 0; fr_rises[k] = 0; fr_first[k] = 0; fr_period[k] = 0; fr_cnt[k] = 0;
            hi_run[k] = 0; last_gap[k] = 0; stray[k] = 0;
            cs_prev[k] = 1'b1; sck_prev[k] = 1'b0; acc_cyc[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rel = cyc - acc_cyc[k];
                if (rsp_valid[k] === 1'b1) begin
                    rv_cnt[k]++; rv_cyc[k] = rel; rv_data[k] = rsp_data[k];
                end
                if (spi_cs_n[k] === 1'b0) begin
                    if (cs_prev[k] === 1'b1) begin
                        cap_mosi[k] = 0; cap_rises[k] = 0; cap_first[k] = 0; cap_period[k] = 0;
                        if (hi_run[k] > 0) last_gap[k] = hi_run[k];
                        hi_run[k] = 0;
                    end
                    if (spi_sck[k] === 1'b1 && sck_prev[k] === 1'b0) begin
                        cap_mosi[k] = {cap_mosi[k][30:0], spi_mosi[k]};
                        if (cap_rises[k] == 0) cap_first[k] = rel;
                        if (cap_rises[k] == 1) cap_period[k] = rel - cap_first[k];
                        cap_rises[k]++;
                    end
                end else begin
                    if (cs_prev[k] === 1'b0) begin
                        fr_mosi[k] = cap_mosi[k]; fr_rises[k] = cap_rises[k];
                        fr_first[k] = cap_first[k]; fr_period[k] = cap_period[k];
                        fr_cnt[k]++;
                    end
                    if (spi_sck[k] === 1'b1 && sck_prev[k] === 1'b0) stray[k]++;
                    hi_run[k]++;
                end
                cs_prev[k]  = spi_cs_n[k];
                sck_prev[k] = spi_sck[k];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int k, input string nm);
        int n;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[k] !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s: req_ready not seen within 2000 cycles", nm);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        return {(we ? 8'h02 : 8'h03), 8'h00, addr, (we ? wdata : 8'h00)};
    endfunction

    task automatic do_txn(input int k, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] sd,
                          input logic [31:0] exp_mosi, input logic exp_valid,
                          input logic [7:0] exp_rsp);
        int d, rv0, fr0, ready_rel;
        d   = (k == 0) ? 1 : 3;
        rv0 = rv_cnt[k];
        fr0 = fr_cnt[k];
        slave_word[k] = {24'($urandom()), sd};
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
        wait_ready(k, "accept");
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom());
        req_addr[k]  = 8'($urandom());
        req_wdata[k] = 8'($urandom());
        chk("busy_in_frame", busy[k], 1'b1);
        chk("ready_in_frame", req_ready[k], 1'b0);
        wait_ready(k, "complete");
        ready_rel = cyc - acc_cyc[k];
        chk("ready_cycle", ready_rel, 2 + 66 * d);
        chk("busy_idle", busy[k], 1'b0);
        chk("mosi_frame", fr_mosi[k], exp_mosi);
        chk("sck_rises", fr_rises[k], 32);
        chk("first_rise_cycle", fr_first[k], 1 + d);
        chk("sck_period", fr_period[k], 2 * d);
        chk("frame_count", fr_cnt[k] - fr0, 1);
        chk("rsp_valid_cycles", rv_cnt[k] - rv0, {31'd0, exp_valid});
        if (exp_valid) chk("rsp_valid_cycle", rv_cyc[k], 1 + 65 * d);
        chk("rsp_data", rsp_data[k], exp_rsp);
        $display("[TB] txn dut%0d D=%0d %s addr=%02h wdata=%02h mosi=%08h rsp_data=%02h ready@%0d",
                 k, d, we ? "WR" : "RD", addr, wdata, fr_mosi[k], rsp_data[k], ready_rel);
    endtask

    initial begin
        logic        we;
        logic [7:0]  addr, wdata, sd, er;
        int          k, a1, n;

        vecs[0] = '{0, 1'b0, 8'h2A, 8'h00, 8'hA5, 32'h03002A00, 1'b1, 8'hA5};
        vecs[1] = '{0, 1'b1, 8'h10, 8'h5C, 8'h77, 32'h0200105C, 1'b0, 8'hA5};
        vecs[2] = '{1, 1'b0, 8'hFF, 8'h00, 8'h3C, 32'h0300FF00, 1'b1, 8'h3C};
        vecs[3] = '{1, 1'b1, 8'h80, 8'hE1, 8'h4D, 32'h020080E1, 1'b0, 8'h3C};

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
            slave_word[i] = 32'h0; rsp_model[i] = 8'h00;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", req_ready[i], 1'b1);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_cs_n", spi_cs_n[i], 1'b1);
            chk("rst_sck", spi_sck[i], 1'b0);
            chk("rst_mosi", spi_mosi[i], 1'b0);
            chk("rst_rsp_valid", rsp_valid[i], 1'b0);
            chk("rst_rsp_data", rsp_data[i], 8'h00);
        end
        rst = 1'b0;

        // directed vectors
        for (int i = 0; i < 4; i++) begin
            do_txn(vecs[i].k, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sdata,
                   vecs[i].exp_mosi, vecs[i].exp_valid, vecs[i].exp_rsp);
            rsp_model[vecs[i].k] = vecs[i].exp_rsp;
        end

        // randomized transactions against the reference model
        for (int i = 0; i < 12; i++) begin
            k     = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = 8'($urandom());
            wdata = 8'($urandom());
            sd    = 8'($urandom());
            er    = we ? rsp_model[k] : sd;
            do_txn(k, we, addr, wdata, sd, frame_of(we, addr, wdata), ~we, er);
            rsp_model[k] = er;
        end

        // back-to-back reads on the CLK_DIV=1 instance with req_valid held
        n = rv_cnt[0];
        slave_word[0] = {24'($urandom()), 8'h11};
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h01; req_wdata[0] = 8'h5A;
        wait_ready(0, "b2b_accept1");
        @(negedge clk);
        a1 = acc_cyc[0];
        req_addr[0] = 8'hEE;
        while (cyc - a1 < 40) @(negedge clk);
        req_addr[0] = 8'h02;
        while (cyc - a1 < 67) @(negedge clk);
        slave_word[0] = {24'($urandom()), 8'h22};
        chk("b2b_f1_mosi", fr_mosi[0], 32'h03000100);
        chk("b2b_f1_rsp", rv_data[0], 8'h11);
        chk("b2b_f1_rsp_cycle", rv_cyc[0], 66);
        chk("b2b_f1_rsp_data", rsp_data[0], 8'h11);
        @(negedge clk);
        chk("b2b_ready_68", req_ready[0], 1'b1);
        @(negedge clk);
        chk("b2b_accept2_cycle", acc_cyc[0] - a1, 68);
        req_valid[0] = 1'b0;
        req_addr[0]  = 8'h99;
        wait_ready(0, "b2b_complete2");
        chk("b2b_f2_mosi", fr_mosi[0], 32'h03000200);
        chk("b2b_f2_rsp", rsp_data[0], 8'h22);
        chk("b2b_rsp_pulses", rv_cnt[0] - n, 2);
        n_tests++;
        if (last_gap[0] < 2 || last_gap[0] > 3) begin
            n_fail++;
            $display("FAIL b2b_cs_gap: actual=%0d required=2..3 cycles", last_gap[0]);
        end
        rsp_model[0] = 8'h22;
        $display("[TB] txn dut0 back-to-back reads 01/02 -> %02h/%02h cs_gap=%0d",
                 rv_data[0], rsp_data[0], last_gap[0]);

        // reset in the middle of a read, during bit 10
        n = rv_cnt[0];
        slave_word[0] = {24'($urandom()), 8'h99};
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h33;
        wait_ready(0, "rst_accept");
        @(negedge clk);
        req_valid[0] = 1'b0;
        a1 = 0;
        while (!(cap_rises[0] >= 11 && spi_sck[0] === 1'b1) && a1 < 500) begin
            @(negedge clk);
            a1++;
        end
        chk("rst_reached_bit10", cap_rises[0], 11);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", spi_cs_n[0], 1'b1);
        chk("mid_rst_sck", spi_sck[0], 1'b0);
        chk("mid_rst_mosi", spi_mosi[0], 1'b0);
        chk("mid_rst_rsp_data", rsp_data[0], 8'h00);
        chk("mid_rst_ready", req_ready[0], 1'b1);
        rst = 1'b0;
        a1 = stray[0];
        repeat (150) @(negedge clk);
        chk("mid_rst_no_rsp", rv_cnt[0] - n, 0);
        chk("mid_rst_no_sck", stray[0] - a1, 0);
        rsp_model[0] = 8'h00;
        rsp_model[1] = 8'h00;
        $display("[TB] txn dut0 read 33 aborted by reset at bit 10");
        sd = 8'($urandom());
        do_txn(0, 1'b0, 8'h07, 8'h00, sd, 32'h03000700, 1'b1, sd);
        rsp_model[0] = sd;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
